// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package fetch_buffer_pkg;

  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;
  // Reserved for flush-time bubble insertion.
  localparam logic [31:0] NopInstr       = 32'hE1A0_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fbuf_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-buffer bundle: imem request/response channels plus the datapath-facing F-stage signals.
interface fetch_buffer_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;

  modport master (
    input  redirect, redirect_pc, stall, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output imem_req_valid, imem_req_addr, instr_valid, instr, pc
  );

  modport slave (
    output redirect, redirect_pc, stall, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  imem_req_valid, imem_req_addr, instr_valid, instr, pc
  );
endinterface

// File: rtl/fetch_buffer_fifo.sv
// Generic Depth x Width FIFO with synchronous clear; a write is accepted when full if a read
// happens in the same cycle.
module fetch_buffer_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             rd_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             wr_en, rd_en;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign rd_en   = rd_i & ~empty_o;
  assign wr_en   = wr_i & (~full_o | rd_en);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (wr_en && !rd_en)      count_q <= count_q + CntW'(1);
      else if (!wr_en && rd_en) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_buffer.sv
// Prefetch queue feeding the F stage; flushes and restarts on redirect.
// Define FETCH_BUFFER_BYPASS_EN to forward a response straight to the outputs when the queue is empty.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned Depth   = 4,
  parameter int unsigned MaxOut  = 2,
  parameter logic [31:0] ResetPc = ResetPcDefault
) (
  input logic            clk,
  input logic            rst,
  fetch_buffer_if.master bus
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned OutW = $clog2(MaxOut + 1);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [OutW-1:0] out_q, out_d, drop_q, drop_d;

  logic            hs, rsp, drop_any, take, bypass;
  logic            q_wr, q_rd, q_full, q_empty;
  logic [CntW-1:0] q_count;
  fbuf_entry_t     q_wdata, q_rdata;

  logic [31:0]     pcf_rdata;
  logic            pcf_full, pcf_empty;
  logic [$clog2(MaxOut + 1)-1:0] pcf_count;

  // Outstanding requests (including ones to be dropped) hold queue credits.
  assign bus.imem_req_valid = ~rst & ~bus.redirect
                            & ((32'(q_count) + 32'(out_q)) < Depth)
                            & (32'(out_q) < MaxOut);
  assign bus.imem_req_addr  = fetch_pc_q;

  assign hs       = bus.imem_req_valid & bus.imem_req_ready;
  assign rsp      = bus.imem_rsp_valid;
  assign drop_any = (drop_q != '0);
  assign take     = rsp & ~drop_any & ~bus.redirect;

`ifdef FETCH_BUFFER_BYPASS_EN
  assign bypass = q_empty & ~drop_any & ~bus.redirect & rsp;
`else
  assign bypass = 1'b0;
`endif

  assign q_wr    = take & ~(bypass & ~bus.stall);
  assign q_rd    = ~q_empty & ~bus.stall & ~bus.redirect;
  assign q_wdata = '{pc: pcf_rdata, instr: bus.imem_rsp_data};

  fetch_buffer_fifo #(
    .Depth (Depth),
    .Width ($bits(fbuf_entry_t))
  ) u_entry_q (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (bus.redirect),
    .wr_i    (q_wr),
    .wdata_i (q_wdata),
    .rd_i    (q_rd),
    .rdata_o (q_rdata),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  // Holds PCs of live (not-to-be-dropped) requests only; cleared on redirect.
  fetch_buffer_fifo #(
    .Depth (MaxOut),
    .Width (32)
  ) u_pc_q (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (bus.redirect),
    .wr_i    (hs),
    .wdata_i (fetch_pc_q),
    .rd_i    (take),
    .rdata_o (pcf_rdata),
    .full_o  (pcf_full),
    .empty_o (pcf_empty),
    .count_o (pcf_count)
  );

  always_comb begin
    out_d      = out_q;
    drop_d     = drop_q;
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect) begin
      out_d      = out_q - OutW'(rsp);
      drop_d     = out_d;
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      out_d = out_q + OutW'(hs) - OutW'(rsp);
      if (rsp && drop_any) drop_d = drop_q - OutW'(1);
      if (hs) fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= ResetPc;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.pc          = '0;
    if (!q_empty) begin
      bus.instr_valid = 1'b1;
      bus.instr       = q_rdata.instr;
      bus.pc          = q_rdata.pc;
    end else if (bypass) begin
      bus.instr_valid = 1'b1;
      bus.instr       = bus.imem_rsp_data;
      bus.pc          = pcf_rdata;
    end
  end

  logic unused_sig;
  assign unused_sig = ^{bus.redirect_pc[1:0], q_full, pcf_full, pcf_empty, pcf_count};

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with an in-order, fixed-latency instruction memory model.
module tb_fetch_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_buffer_if bus ();

  fetch_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef FETCH_BUFFER_BYPASS_EN
  localparam int FirstCyc = 1;
`else
  localparam int FirstCyc = 2;
`endif

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    cyc;
  int    lat = 1;
  int    checks = 0;
  int    passes = 0;
  int    fails = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hD000_0000 | a;
  endfunction

  // Memory: always ready, responds lat cycles after the handshake, in order.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      cyc <= 0;
      bus.imem_rsp_valid <= 1'b0;
      bus.imem_rsp_data  <= '0;
    end else begin
      if (bus.imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready)
        mq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
      cyc <= cyc + 1;
      if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
        bus.imem_rsp_valid <= 1'b1;
        bus.imem_rsp_data  <= word_at(mq[0].addr);
      end else begin
        bus.imem_rsp_valid <= 1'b0;
        bus.imem_rsp_data  <= '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (failure #%0d)", tag, obs, exp, fails);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    chk({tag, "_pc"}, bus.pc, pc);
    chk({tag, "_instr"}, bus.instr, word_at(pc));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, "_instr"}, bus.instr, 32'd0);
    chk({tag, "_pc"}, bus.pc, 32'd0);
  endtask

  task automatic start(input int l);
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    lat = l;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_req_ready = 1'b1;
    lat = 1;
    tick();
    chk_empty("reset");
    chk("reset_req_valid", 32'(bus.imem_req_valid), 32'd0);
    tick();
    rst = 1'b0;
    #1;

    // 1: streaming with 1-cycle memory
    chk("t1_c0_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t1_c0_addr", bus.imem_req_addr, 32'h0);
    chk("t1_c0_valid", 32'(bus.instr_valid), 32'd0);
    tick();
`ifdef FETCH_BUFFER_BYPASS_EN
    chk_head("t1_c1", 32'h0);
`else
    chk("t1_c1_valid", 32'(bus.instr_valid), 32'd0);
`endif
    chk("t1_c1_addr", bus.imem_req_addr, 32'h4);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk_head($sformatf("t1_c%0d", k), 32'(4 * (k - FirstCyc)));
    end
    chk("t1_c4_addr", bus.imem_req_addr, 32'h10);

`ifndef FETCH_BUFFER_BYPASS_EN
    // 2: stall fills the queue to Depth, then drains without gaps
    bus.stall = 1'b1;
    tick();
    tick();
    chk("t2_c6_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk_head("t2_c6", 32'h8);
    repeat (7) tick();
    chk("t2_c13_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk_head("t2_c13", 32'h8);
    bus.stall = 1'b0;
    tick();
    chk_head("t2_c14", 32'hC);
    chk("t2_c14_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t2_c14_addr", bus.imem_req_addr, 32'h18);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_head($sformatf("t2_drain%0d", k), 32'h10 + 32'(4 * k));
    end

    // 3: redirect with two requests in flight (3-cycle memory); low PC bits ignored
    start(3);
    tick();
    chk("t3_c1_addr", bus.imem_req_addr, 32'h4);
    tick();
    chk("t3_c2_req_valid", 32'(bus.imem_req_valid), 32'd0);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h103;
    tick();
    chk("t3_c3_valid", 32'(bus.instr_valid), 32'd0);
    bus.redirect = 1'b0;
    #1;
    chk("t3_c3_req_valid", 32'(bus.imem_req_valid), 32'd0);
    tick();
    chk("t3_c4_valid", 32'(bus.instr_valid), 32'd0);
    chk("t3_c4_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t3_c4_addr", bus.imem_req_addr, 32'h100);
    tick();
    chk("t3_c5_valid", 32'(bus.instr_valid), 32'd0);
    chk("t3_c5_addr", bus.imem_req_addr, 32'h104);
    tick();
    tick();
    chk("t3_c7_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    chk_head("t3_c8", 32'h100);
    tick();
    chk_head("t3_c9", 32'h104);

    // 4: redirect coinciding with a response and a pop
    start(1);
    repeat (3) tick();
    chk_head("t4_c3", 32'h4);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    chk_empty("t4_c4");
    bus.redirect = 1'b0;
    #1;
    chk("t4_c4_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t4_c4_addr", bus.imem_req_addr, 32'h40);
    tick();
    chk("t4_c5_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    chk_head("t4_c6", 32'h40);
    tick();
    chk_head("t4_c7", 32'h44);

    // 5: back-to-back redirects, only the second target survives
    start(3);
    tick();
    tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    tick();
    bus.redirect_pc = 32'h300;
    chk("t5_c3_req_valid", 32'(bus.imem_req_valid), 32'd0);
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("t5_c4_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t5_c4_addr", bus.imem_req_addr, 32'h300);
    for (int k = 4; k <= 7; k++) begin
      if (k > 4) tick();
      chk($sformatf("t5_c%0d_valid", k), 32'(bus.instr_valid), 32'd0);
    end
    tick();
    chk_head("t5_c8", 32'h300);
    tick();
    chk_head("t5_c9", 32'h304);

    // 6: asynchronous reset between edges
    start(1);
    repeat (3) tick();
    chk_head("t6_c3", 32'h4);
    #2;
    rst = 1'b1;
    #1;
    chk_empty("t6_async");
    chk("t6_async_req_valid", 32'(bus.imem_req_valid), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_c0_addr", bus.imem_req_addr, 32'h0);
    tick();
    tick();
    chk_head("t6_c2", 32'h0);
    tick();
    chk_head("t6_c3b", 32'h4);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
